// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: FSM states, constants, word alignment.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int PC_W       = 32;
    localparam int WORD_OFS_W = 2;

    localparam logic [PC_W-1:0] ZERO          = '0;
    localparam logic [PC_W-1:0] WORD_OFS_MASK = PC_W'((1 << WORD_OFS_W) - 1);

    // Fetch addresses are word aligned; the low byte-offset bits are ignored.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
        return pc & ~WORD_OFS_MASK;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// Latency: n/a (wiring only).
// Backpressure: IF holds if_pc while if_busy; controller done/pc qualify returned words.
// Modports: slave = the cache, master = IF stage plus memory controller.
interface icache_if;
    import icache_pkg::*;

    logic            if_req;
    logic [PC_W-1:0] if_pc;
    logic            if_flush;
    logic            if_valid;
    logic [PC_W-1:0] if_inst;
    logic [PC_W-1:0] if_inst_pc;
    logic            if_busy;
    logic            mc_inst_req;
    logic [PC_W-1:0] mc_inst_addr;
    logic [PC_W-1:0] mc_inst;
    logic [PC_W-1:0] mc_inst_pc;
    logic            mc_inst_done;

    modport slave (
        input  if_req, if_pc, if_flush, mc_inst, mc_inst_pc, mc_inst_done,
        output if_valid, if_inst, if_inst_pc, if_busy, mc_inst_req, mc_inst_addr
    );

    modport master (
        output if_req, if_pc, if_flush, mc_inst, mc_inst_pc, mc_inst_done,
        input  if_valid, if_inst, if_inst_pc, if_busy, mc_inst_req, mc_inst_addr
    );
endinterface

// File: rtl/icache_array.sv
// Direct-mapped tag/valid/data storage: one async read port, one write port, flush-all.
// Latency: read is combinational; write and flush take effect at the next clock edge.
// Backpressure: none; flush overrides a simultaneous write.
// Ports: clk, rst (async active-low), flush_i, rd_idx_i -> rd_vld_o/rd_tag_o/rd_dat_o,
//        wr_en_i/wr_idx_i/wr_tag_i/wr_dat_i.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 7,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_vld_o,
    output logic [TAG_BITS-1:0]   rd_tag_o,
    output logic [PC_W-1:0]       rd_dat_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [PC_W-1:0]       wr_dat_i
);
    localparam int LINES = 2 ** INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_mem_q  [LINES];
    logic [PC_W-1:0]     data_mem_q [LINES];

    // Only the valid bits are reset; stale tag/data are harmless behind a 0 valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= TRUE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i && !flush_i) begin
            tag_mem_q[wr_idx_i]  <= wr_tag_i;
            data_mem_q[wr_idx_i] <= wr_dat_i;
        end
    end

    assign rd_vld_o = valid_q[rd_idx_i];
    assign rd_tag_o = tag_mem_q[rd_idx_i];
    assign rd_dat_o = data_mem_q[rd_idx_i];
endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache between IF and the memory controller.
// Latency: hit 1 cycle (registered); miss = request + controller latency + 1.
// Backpressure: if_busy holds IF during a refill; the refill request is held until the word returns.
// Ports: clk, rst (async active-low), bus (icache_if.slave);
//        hit_cnt/miss_cnt only when ICACHE_STATS_EN is defined.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 7
) (
    input  logic     clk,
    input  logic     rst,
    icache_if.slave  bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int IDX_LO   = WORD_OFS_W;
    localparam int TAG_LO   = INDEX_BITS + WORD_OFS_W;

    state_t          state_q, state_d;
    logic            valid_q, valid_d;
    logic [PC_W-1:0] inst_q, inst_d;
    logic [PC_W-1:0] inst_pc_q, inst_pc_d;
    logic [PC_W-1:0] mc_addr_q, mc_addr_d;

    logic [PC_W-1:0]       pc_al;
    logic [INDEX_BITS-1:0] rd_idx, wr_idx;
    logic [TAG_BITS-1:0]   pc_tag, wr_tag, rd_tag;
    logic [PC_W-1:0]       rd_dat;
    logic                  rd_vld, hit, redirect, mc_match;
    logic                  wr_en, hit_evt, miss_evt;

    assign pc_al  = word_align(bus.if_pc);
    assign rd_idx = pc_al[INDEX_BITS+1:IDX_LO];
    assign pc_tag = pc_al[PC_W-1:TAG_LO];
    assign wr_idx = mc_addr_q[INDEX_BITS+1:IDX_LO];
    assign wr_tag = mc_addr_q[PC_W-1:TAG_LO];

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (bus.if_flush),
        .rd_idx_i (rd_idx),
        .rd_vld_o (rd_vld),
        .rd_tag_o (rd_tag),
        .rd_dat_o (rd_dat),
        .wr_en_i  (wr_en),
        .wr_idx_i (wr_idx),
        .wr_tag_i (wr_tag),
        .wr_dat_i (bus.mc_inst)
    );

    assign hit      = rd_vld && (rd_tag == pc_tag);
    // IF moved away from the address being refilled: the old refill is worthless.
    assign redirect = (state_q != IDLE) && (pc_al != mc_addr_q);
    // The controller's done is only trusted when it carries our address.
    assign mc_match = bus.mc_inst_done && (bus.mc_inst_pc == mc_addr_q);

    always_comb begin
        state_d   = state_q;
        valid_d   = FALSE;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        mc_addr_d = mc_addr_q;
        wr_en     = FALSE;
        hit_evt   = FALSE;
        miss_evt  = FALSE;
        if (bus.if_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.if_req) begin
                        if (hit) begin
                            valid_d   = TRUE;
                            inst_d    = rd_dat;
                            inst_pc_d = pc_al;
                            hit_evt   = TRUE;
                        end else begin
                            state_d   = REQ;
                            mc_addr_d = pc_al;
                            miss_evt  = TRUE;
                        end
                    end
                end
                // done=1 here is the controller idling or reporting an older fetch;
                // only a low done proves our request was taken.
                REQ: begin
                    if (redirect) begin
                        mc_addr_d = pc_al;
                    end else if (!bus.mc_inst_done) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        mc_addr_d = pc_al;
                        state_d   = REQ;
                    end else if (mc_match) begin
                        wr_en     = TRUE;
                        valid_d   = TRUE;
                        inst_d    = bus.mc_inst;
                        inst_pc_d = mc_addr_q;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            valid_q   <= FALSE;
            inst_q    <= ZERO;
            inst_pc_q <= ZERO;
            mc_addr_q <= ZERO;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            mc_addr_q <= mc_addr_d;
        end
    end

    assign bus.if_valid     = valid_q;
    assign bus.if_inst      = inst_q;
    assign bus.if_inst_pc   = inst_pc_q;
    assign bus.if_busy      = (state_q != IDLE);
    assign bus.mc_inst_req  = (state_q != IDLE);
    assign bus.mc_inst_addr = mc_addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_evt)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_evt) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: scoreboard of expected deliveries plus per-scenario checks.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench drives IF and controller directly).
module tb_icache;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    icache_if bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    icache #(.INDEX_BITS(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Every delivered word must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && bus.if_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got pc=%h inst=%h, required no delivery",
                         bus.if_inst_pc, bus.if_inst);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.if_inst !== mon_e.inst || bus.if_inst_pc !== mon_e.pc) begin
                    errors++;
                    $display("FAIL delivery: got pc=%h inst=%h, required pc=%h inst=%h",
                             bus.if_inst_pc, bus.if_inst, mon_e.pc, mon_e.inst);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Controller model: accept (done low) for lat cycles, then return the word.
    task automatic serve(input logic [31:0] addr, input logic [31:0] data, input int lat);
        bus.mc_inst_done = 1'b0;
        repeat (lat) @(negedge clk);
        bus.mc_inst_done = 1'b1;
        bus.mc_inst_pc   = addr;
        bus.mc_inst      = data;
        @(negedge clk);
        bus.if_req = 1'b0;
    endtask

    task automatic test_reset;
        bus.if_req = 1'b0; bus.if_pc = '0; bus.if_flush = 1'b0;
        bus.mc_inst_done = 1'b1; bus.mc_inst = '0; bus.mc_inst_pc = '0;
        rst = 1'b0;
        #2;
        checks++;
        if ({bus.if_valid, bus.if_busy, bus.mc_inst_req} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got valid/busy/req=%b, required 000",
                     {bus.if_valid, bus.if_busy, bus.mc_inst_req});
        end
        checks++;
        if (bus.if_inst !== 32'h0 || bus.if_inst_pc !== 32'h0 || bus.mc_inst_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got inst=%h pc=%h addr=%h, required all 0",
                     bus.if_inst, bus.if_inst_pc, bus.mc_inst_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cold_miss;
        exp_q.push_back({32'h0000_1000, 32'h0000_0013});
        bus.if_req = 1'b1; bus.if_pc = 32'h0000_1000;
        @(negedge clk);
        checks++;
        if (bus.mc_inst_req !== 1'b1 || bus.mc_inst_addr !== 32'h1000 ||
            bus.if_busy !== 1'b1 || bus.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL cold_miss_req: got req=%b addr=%h busy=%b valid=%b, required 1 1000 1 0",
                     bus.mc_inst_req, bus.mc_inst_addr, bus.if_busy, bus.if_valid);
        end
        serve(32'h1000, 32'h13, 6);
        checks++;
        if (bus.if_valid !== 1'b1 || bus.mc_inst_req !== 1'b0 || bus.if_busy !== 1'b0) begin
            errors++;
            $display("FAIL cold_miss_done: got valid=%b req=%b busy=%b, required 1 0 0",
                     bus.if_valid, bus.mc_inst_req, bus.if_busy);
        end
        @(negedge clk); #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL cold_miss_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_hit_refetch;
        exp_q.push_back({32'h0000_1000, 32'h0000_0013});
        bus.if_req = 1'b1; bus.if_pc = 32'h0000_1002;  // low bits ignored
        @(negedge clk);
        checks++;
        if (bus.if_valid !== 1'b1 || bus.mc_inst_req !== 1'b0) begin
            errors++;
            $display("FAIL refetch_hit: got valid=%b req=%b, required 1 0", bus.if_valid, bus.mc_inst_req);
        end
        bus.if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.if_valid !== 1'b0 || bus.mc_inst_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: got valid=%b req=%b, required 0 0", bus.if_valid, bus.mc_inst_req);
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL refetch_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_conflict;
        logic [31:0] a [2];
        logic [31:0] d [2];
        a[0] = 32'h0000_1200; d[0] = 32'hAAAA_0001;
        a[1] = 32'h0000_1000; d[1] = 32'h0000_0013;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({a[i], d[i]});
            bus.if_req = 1'b1; bus.if_pc = a[i];
            @(negedge clk);
            checks++;
            if (bus.mc_inst_req !== 1'b1 || bus.if_valid !== 1'b0 || bus.mc_inst_addr !== a[i]) begin
                errors++;
                $display("FAIL conflict_miss: got req=%b valid=%b addr=%h, required 1 0 %h",
                         bus.mc_inst_req, bus.if_valid, bus.mc_inst_addr, a[i]);
            end
            serve(a[i], d[i], 2);
        end
        @(negedge clk); #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL conflict_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_stale_done;
        bus.if_flush = 1'b1; bus.if_req = 1'b1; bus.if_pc = 32'h1000;
        @(negedge clk);
        checks++;
        if (bus.if_valid !== 1'b0 || bus.mc_inst_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_hit: got valid=%b req=%b, required 0 0", bus.if_valid, bus.mc_inst_req);
        end
        bus.if_flush = 1'b0;
        bus.mc_inst_done = 1'b1; bus.mc_inst_pc = 32'h1000; bus.mc_inst = 32'h13;
        exp_q.push_back({32'h0000_1000, 32'h0000_0013});
        @(negedge clk);
        checks++;
        if (bus.mc_inst_req !== 1'b1) begin
            errors++;
            $display("FAIL miss_after_flush: got req=%b, required 1", bus.mc_inst_req);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.if_valid !== 1'b0 || bus.mc_inst_req !== 1'b1) begin
                errors++;
                $display("FAIL stale_done_ignored: got valid=%b req=%b, required 0 1",
                         bus.if_valid, bus.mc_inst_req);
            end
        end
        serve(32'h1000, 32'h13, 2);
        checks++;
        if (bus.if_valid !== 1'b1) begin
            errors++;
            $display("FAIL stale_done_deliver: got valid=%b, required 1", bus.if_valid);
        end
        @(negedge clk); #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stale_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_redirect;
        exp_q.push_back({32'h0000_3000, 32'h0000_0033});
        bus.if_req = 1'b1; bus.if_pc = 32'h2000;
        @(negedge clk);
        bus.mc_inst_done = 1'b0;
        repeat (2) @(negedge clk);
        bus.if_pc = 32'h3000;
        @(negedge clk);
        checks++;
        if (bus.mc_inst_addr !== 32'h3000 || bus.mc_inst_req !== 1'b1) begin
            errors++;
            $display("FAIL redirect_addr: got addr=%h req=%b, required 3000 1",
                     bus.mc_inst_addr, bus.mc_inst_req);
        end
        @(negedge clk);
        bus.mc_inst_done = 1'b1; bus.mc_inst_pc = 32'h2000; bus.mc_inst = 32'hDEAD_0000;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.if_valid !== 1'b0 || bus.mc_inst_req !== 1'b1) begin
            errors++;
            $display("FAIL late_old_ignored: got valid=%b req=%b, required 0 1",
                     bus.if_valid, bus.mc_inst_req);
        end
        serve(32'h3000, 32'h33, 2);
        // 0x3000 must now hit; 0x2000 must not have been cached.
        exp_q.push_back({32'h0000_3000, 32'h0000_0033});
        bus.if_req = 1'b1; bus.if_pc = 32'h3000;
        @(negedge clk);
        checks++;
        if (bus.if_valid !== 1'b1 || bus.mc_inst_req !== 1'b0) begin
            errors++;
            $display("FAIL redirect_cached: got valid=%b req=%b, required 1 0", bus.if_valid, bus.mc_inst_req);
        end
        exp_q.push_back({32'h0000_2000, 32'h0000_0022});
        bus.if_pc = 32'h2000;
        @(negedge clk);
        checks++;
        if (bus.mc_inst_req !== 1'b1) begin
            errors++;
            $display("FAIL old_not_cached: got req=%b, required 1", bus.mc_inst_req);
        end
        serve(32'h2000, 32'h22, 2);
        @(negedge clk); #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL redirect_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_flush_vs_done;
`ifdef ICACHE_STATS_EN
        logic [31:0] m0;
        m0 = miss_cnt;
`endif
        bus.if_req = 1'b1; bus.if_pc = 32'h4000;
        @(negedge clk);
        bus.mc_inst_done = 1'b0;
        @(negedge clk);
        bus.mc_inst_done = 1'b1; bus.mc_inst_pc = 32'h4000; bus.mc_inst = 32'h44;
        bus.if_flush = 1'b1; bus.if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.if_valid !== 1'b0 || bus.mc_inst_req !== 1'b0 || bus.if_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_beats_done: got valid=%b req=%b busy=%b, required 0 0 0",
                     bus.if_valid, bus.mc_inst_req, bus.if_busy);
        end
        bus.if_flush = 1'b0;
        exp_q.push_back({32'h0000_4000, 32'h0000_0044});
        bus.if_req = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mc_inst_req !== 1'b1 || bus.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL flushed_line_invalid: got req=%b valid=%b, required 1 0",
                     bus.mc_inst_req, bus.if_valid);
        end
`ifdef ICACHE_STATS_EN
        checks++;
        if (miss_cnt !== m0 + 32'd2) begin
            errors++;
            $display("FAIL miss_cnt: got %0d, required %0d", miss_cnt, m0 + 32'd2);
        end
`endif
        serve(32'h4000, 32'h44, 3);
        @(negedge clk); #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL flush_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a [3];
        logic [31:0] d [3];
`ifdef ICACHE_STATS_EN
        logic [31:0] h0;
`endif
        a[0] = 32'h1004; d[0] = 32'h0010_0093;
        a[1] = 32'h1008; d[1] = 32'h0020_0113;
        a[2] = 32'h100C; d[2] = 32'h0030_0193;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({a[i], d[i]});
            bus.if_req = 1'b1; bus.if_pc = a[i];
            @(negedge clk);
            serve(a[i], d[i], 1);
        end
        @(negedge clk);
`ifdef ICACHE_STATS_EN
        h0 = hit_cnt;
`endif
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({a[i], d[i]});
            bus.if_req = 1'b1; bus.if_pc = a[i];
            @(negedge clk);
            checks++;
            if (bus.if_valid !== 1'b1 || bus.mc_inst_req !== 1'b0) begin
                errors++;
                $display("FAIL b2b_hit: got valid=%b req=%b, required 1 0", bus.if_valid, bus.mc_inst_req);
            end
        end
        bus.if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: got valid=%b, required 0", bus.if_valid);
        end
`ifdef ICACHE_STATS_EN
        checks++;
        if (hit_cnt !== h0 + 32'd3) begin
            errors++;
            $display("FAIL hit_cnt: got %0d, required %0d", hit_cnt, h0 + 32'd3);
        end
`endif
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_refill;
        bus.if_req = 1'b1; bus.if_pc = 32'h5000;
        @(negedge clk);
        bus.mc_inst_done = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.mc_inst_req !== 1'b0 || bus.if_busy !== 1'b0 || bus.mc_inst_addr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got req=%b busy=%b addr=%h, required 0 0 0",
                     bus.mc_inst_req, bus.if_busy, bus.mc_inst_addr);
        end
        @(negedge clk);
        rst = 1'b1; bus.if_req = 1'b0;
        bus.mc_inst_done = 1'b1; bus.mc_inst_pc = 32'h5000; bus.mc_inst = 32'h55;
        repeat (2) @(negedge clk);
`ifdef ICACHE_STATS_EN
        checks++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            errors++;
            $display("FAIL stats_reset: got hit=%0d miss=%0d, required 0 0", hit_cnt, miss_cnt);
        end
`endif
        exp_q.push_back({32'h0000_1004, 32'h0010_0093});
        bus.if_req = 1'b1; bus.if_pc = 32'h1004;
        @(negedge clk);
        checks++;
        if (bus.mc_inst_req !== 1'b1 || bus.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_miss: got req=%b valid=%b, required 1 0", bus.mc_inst_req, bus.if_valid);
        end
        serve(32'h1004, 32'h0010_0093, 2);
        @(negedge clk); #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_refetch();
        test_conflict();
        test_stale_done();
        test_redirect();
        test_flush_vs_done();
        test_back_to_back();
        test_reset_mid_refill();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, one-word-per-line instruction cache between the IF stage and the instruction port of the memory controller.
- Serves fetch PCs with registered 1-cycle hit latency.
- On a miss, holds a refill request to the controller until the matching word returns, writes it into the array, then delivers it.
- Read-only; no write/coherence path other than a full flush.

Parameters:
INDEX_BITS, 7, line-index width; lines = 2**INDEX_BITS, index = pc[INDEX_BITS+1:2]
TAG_BITS, 30-INDEX_BITS (derived localparam), tag = pc[31:INDEX_BITS+2]

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
if_req  in  1  IF stage requests instruction at if_pc this cycle
if_pc  in  32  fetch address, word aligned (bits[1:0] ignored)
if_flush  in  1  invalidate all lines and abort any refill
if_valid  out  1  one-cycle pulse: if_inst/if_inst_pc valid
if_inst  out  32  instruction word
if_inst_pc  out  32  address of if_inst
if_busy  out  1  miss in progress; IF must hold if_pc stable
mc_inst_req  out  1  refill request to memory controller
mc_inst_addr  out  32  refill address (word aligned)
mc_inst  in  32  word returned by controller
mc_inst_pc  in  32  address of mc_inst
mc_inst_done  in  1  controller done flag (also high while controller is idle)

Behaviour:
- Reset (rst=0, async): all valid bits 0, state IDLE, if_valid=0, if_inst=0, if_inst_pc=0, if_busy=0, mc_inst_req=0, mc_inst_addr=0. Tag/data arrays are not reset.
- IDLE, if_req=1, hit (valid[idx] && tag match): next edge if_valid=1, if_inst=data[idx], if_inst_pc={if_pc[31:2],2'b00}. Back-to-back hits give one result per cycle.
- IDLE, if_req=1, miss: next edge state=REQ, mc_inst_req=1, mc_inst_addr=aligned pc, if_busy=1, if_valid=0.
- REQ: waits for mc_inst_done=0, which proves the controller accepted the request. The controller's idle-state done=1 and stale results are therefore ignored. Then state=WAIT.
- WAIT: on mc_inst_done=1 && mc_inst_pc==mc_inst_addr:
  - write data[idx]=mc_inst, tag, valid=1;
  - if_valid=1, if_inst=mc_inst, if_inst_pc=mc_inst_addr;
  - mc_inst_req=0, if_busy=0, state=IDLE.
  - A done with a mismatching pc is ignored.
- If if_pc changes while busy (redirect): drop the current refill, reissue mc_inst_addr=new pc, return to REQ. The controller restarts on address change.
- if_flush (priority over everything, synchronous):
  - clear all valid bits in one cycle;
  - mc_inst_req=0, if_busy=0, if_valid=0, state=IDLE;
  - the flush cycle never produces a hit even when if_req=1.
- Simultaneous refill completion and flush: flush wins; nothing is written and if_valid stays 0.
- Reset mid-refill: all state clears immediately. The controller may finish its fetch later; REQ gating discards it.
- if_req=0 in IDLE: if_valid=0, no controller traffic.

Optional Feature:
ICACHE_STATS_EN
- Defined:
  - adds outputs hit_cnt[31:0] and miss_cnt[31:0];
  - hit_cnt increments on each IDLE hit that produces if_valid;
  - miss_cnt increments on each IDLE->REQ transition (redirect reissues not counted);
  - both wrap at 2**32, reset to 0, and are not cleared by flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/define file holds:
  - state encodings IDLE/REQ/WAIT;
  - True/False and Zero constants already in use;
  - word-align helper width constants.
- One natural sub-module, icache_array: tag/valid/data storage with one read port, one write port, and a flush-all input.

Test Plan:
1. Cold miss: if_pc=0x0000_1000, controller returns 0x0000_0013 after 6 cycles -> single if_valid, if_inst=0x13, if_inst_pc=0x1000; mc_inst_req drops the same edge.
2. Re-fetch 0x1000 after scenario 1 -> if_valid one cycle later with 0x13, mc_inst_req stays 0.
3. Conflict (INDEX_BITS=7): fetch 0x1000 then 0x1200 (same index) -> both miss; a third fetch of 0x1000 misses again.
4. Idle controller holds done=1 with stale pc=0x1000 while a 0x1000 miss is issued -> no if_valid until done has gone 0 then 1.
5. Redirect mid-refill from 0x2000 to 0x3000 -> mc_inst_addr=0x3000, a late 0x2000 completion is ignored, only 0x3000 is delivered and cached.
6. if_flush the same cycle as refill done -> no if_valid, line stays invalid, next fetch misses; with ICACHE_STATS_EN, miss_cnt increments.
